iob_ram_responder: RTL and testbench

//  IOb native-bus responder (subordinate) backed by a word-organised, byte-writable RAM.

---
 rtl/iob_ram_responder_pkg.sv | 18 +
 rtl/iob_ram_responder_if.sv | 26 ++
 rtl/iob_ram_responder_ram.sv | 33 +++
 rtl/iob_ram_responder.sv | 127 ++++++++++++
 tb/tb_iob_ram_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/iob_ram_responder_pkg.sv
// Shared types and constants for the IOb RAM responder: FSM state encoding
// and wait-state counter width.
package iob_ram_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of byte-offset address bits dropped to form a word index.
  function automatic int offset_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_ram_responder_if.sv
// IOb native bus bundle: request channel driven by the initiator,
// ready/response channel driven by the responder.
interface iob_ram_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  iob_valid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic [DATA_W-1:0]     iob_rdata;
  logic                  iob_rvalid;
  logic                  iob_ready;

  modport master (
    output iob_valid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rdata, iob_rvalid, iob_ready
  );

  modport slave (
    input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rdata, iob_rvalid, iob_ready
  );

endinterface

// File: rtl/iob_ram_responder_ram.sv
// iob_ram_sp_be: single-port word RAM with per-byte write enables and a
// registered, enable-gated read port that holds its value between reads.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W/8-1:0] we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array is deliberately not reset so it maps onto RAM
  // macros; only the read-data register gets a reset value.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/iob_ram_responder.sv
// IOb responder backed by a byte-writable RAM: zero-wait writes, reads after
// WAIT_STATES extra cycles. Define IOB_RAM_RESPONDER_ADDR_CHECK_EN to flag
// out-of-range addresses on err_o instead of aliasing them.
module iob_ram_responder
  import iob_ram_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  iob_ram_responder_if.slave   bus,
  output logic                 err_o
);

  localparam int                NB    = DATA_W / 8;
  localparam int                OFF_W = offset_bits(DATA_W);
  localparam logic [CNT_W-1:0]  WS    = CNT_W'(WAIT_STATES);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [MEM_ADDR_W-1:0]   bus_idx, idx_q, ram_addr;
  logic                    accept, is_write, oor;
  logic                    rd_oor_q, resp_oor_q;
  logic                    ram_re;
  logic [NB-1:0]           ram_we;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    unused_addr;

  assign bus.iob_ready = (state == ST_IDLE);
  assign accept        = bus.iob_valid & bus.iob_ready & cke_i;
  assign is_write      = |bus.iob_wstrb;
  assign bus_idx       = bus.iob_addr[MEM_ADDR_W+OFF_W-1:OFF_W];
  assign unused_addr   = ^bus.iob_addr;

`ifdef IOB_RAM_RESPONDER_ADDR_CHECK_EN
  assign oor = |(bus.iob_addr >> (MEM_ADDR_W + OFF_W));
`else
  assign oor = 1'b0;
`endif

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && !is_write) begin
          cnt_n   = WS;
          state_n = (WS == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt <= 1) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (cke_i) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Read context captured at acceptance; the response flag is captured with
  // the RAM read so rdata stays stable until the next response.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      idx_q      <= '0;
      rd_oor_q   <= 1'b0;
      resp_oor_q <= 1'b0;
    end else begin
      if (accept && !is_write) begin
        idx_q    <= bus_idx;
        rd_oor_q <= oor;
      end
      if (ram_re) resp_oor_q <= (state == ST_IDLE) ? oor : rd_oor_q;
    end
  end

  assign ram_addr = (state == ST_IDLE) ? bus_idx : idx_q;
  assign ram_re   = cke_i & (state_n == ST_RESP);
  assign ram_we   = (accept && is_write && !oor) ? bus.iob_wstrb : '0;

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.iob_wdata),
    .rdata (ram_rdata)
  );

  assign bus.iob_rvalid = (state == ST_RESP);
  assign bus.iob_rdata  = resp_oor_q ? '0 : ram_rdata;

`ifdef IOB_RAM_RESPONDER_ADDR_CHECK_EN
  logic wr_err_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  wr_err_q <= 1'b0;
    else if (cke_i) wr_err_q <= accept & is_write & oor;
  end

  assign err_o = wr_err_q | (bus.iob_rvalid & resp_oor_q);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_ram_responder.sv
// Scoreboard bench for iob_ram_responder: dut0 with WAIT_STATES=1, dut1 with
// WAIT_STATES=0. Expectations follow IOB_RAM_RESPONDER_ADDR_CHECK_EN.
module tb_iob_ram_responder;

`ifdef IOB_RAM_RESPONDER_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0, rst_n1, cke0, cke1;
  logic err0, err1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q0[$];
  exp_t q1[$];

  iob_ram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  iob_ram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

  iob_ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_STATES(1)) dut0 (
    .clk_i(clk), .arst_n_i(rst_n0), .cke_i(cke0), .bus(bus0), .err_o(err0));

  iob_ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_STATES(0)) dut1 (
    .clk_i(clk), .arst_n_i(rst_n1), .cke_i(cke1), .bus(bus1), .err_o(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n0 && bus0.iob_rvalid === 1'b1) begin
      if (q0.size() == 0) check("dut0_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("dut0_rdata", bus0.iob_rdata, e.data);
        check("dut0_err_with_rvalid", {31'd0, err0}, {31'd0, e.err});
        check("dut0_rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n1 && bus1.iob_rvalid === 1'b1) begin
      if (q1.size() == 0) check("dut1_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("dut1_rdata", bus1.iob_rdata, e.data);
        check("dut1_err_with_rvalid", {31'd0, err1}, {31'd0, e.err});
        check("dut1_rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? (bus1.iob_ready & cke1) : (bus0.iob_ready & cke0);
  endfunction

  // Drive a request (valid left high) and return the cycle it was accepted.
  task automatic issue(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output int acc);
    if (sel) begin
      bus1.iob_valid = 1'b1; bus1.iob_addr = addr; bus1.iob_wdata = wdata; bus1.iob_wstrb = strb;
    end else begin
      bus0.iob_valid = 1'b1; bus0.iob_addr = addr; bus0.iob_wdata = wdata; bus0.iob_wstrb = strb;
    end
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      @(negedge clk);
      if (rdy(sel)) acc = cyc;
    end
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drop(input bit sel);
    if (sel) bus1.iob_valid = 1'b0; else bus0.iob_valid = 1'b0;
  endtask

  task automatic write(input bit sel, input logic [31:0] addr, input logic [31:0] d,
                       input logic [3:0] strb);
    int acc;
    issue(sel, addr, d, strb, acc);
    drop(sel);
  endtask

  task automatic read(input bit sel, input logic [31:0] addr, input logic [31:0] d,
                      input logic err, input int ws, input int stall);
    int acc;
    exp_t e;
    issue(sel, addr, 32'h0, 4'h0, acc);
    e.data = d; e.err = err; e.cyc = acc + ws + 1 + stall;
    if (sel) q1.push_back(e); else q0.push_back(e);
    drop(sel);
  endtask

  // Count cycles with ready low until the responder is idle again.
  task automatic wait_idle(input bit sel, output int low);
    bit done = 1'b0;
    low = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if ((sel ? bus1.iob_ready : bus0.iob_ready) === 1'b1) done = 1'b1;
      else low++;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int low, acc;
    exp_t e;
    logic [31:0] alias_val;

    rst_n0 = 1'b0; rst_n1 = 1'b0; cke0 = 1'b1; cke1 = 1'b1;
    bus0.iob_valid = 1'b0; bus0.iob_addr = '0; bus0.iob_wdata = '0; bus0.iob_wstrb = '0;
    bus1.iob_valid = 1'b0; bus1.iob_addr = '0; bus1.iob_wdata = '0; bus1.iob_wstrb = '0;
    repeat (3) @(posedge clk);
    #1; rst_n0 = 1'b1; rst_n1 = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_ready", {31'd0, bus0.iob_ready}, 32'd1);
    check("reset_rvalid", {31'd0, bus0.iob_rvalid}, 32'd0);
    check("reset_rdata", bus0.iob_rdata, 32'h0);
    check("reset_err", {31'd0, err0}, 32'd0);
    check("reset_ready_dut1", {31'd0, bus1.iob_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: full write then read, ready stays high on write
    write(0, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("ready_after_write", {31'd0, bus0.iob_ready}, 32'd1);
    check("no_rvalid_on_write", {31'd0, bus0.iob_rvalid}, 32'd0);
    @(posedge clk); #1;
    read(0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0);
    wait_idle(0, low);
    check("read_ready_low_cycles", low, 32'd2);

    // 2: back-to-back writes incl. byte strobe, read in the very next cycle
    issue(0, 32'h20, 32'h11223344, 4'hF, acc);
    issue(0, 32'h20, 32'h0000AA00, 4'h2, acc);
    read(0, 32'h20, 32'h1122AA44, 1'b0, 1, 0);
    wait_idle(0, low);
    write(0, 32'h30, 32'hCAFEF00D, 4'hF);
    read(0, 32'h30, 32'hCAFEF00D, 1'b0, 1, 0);
    wait_idle(0, low);

    // 3: valid held high across two reads
    bus0.iob_valid = 1'b1; bus0.iob_addr = 32'h10; bus0.iob_wstrb = 4'h0;
    acc = 0; low = 0;
    for (int k = 0; k < 40 && acc < 2; k++) begin
      @(negedge clk);
      if (bus0.iob_ready === 1'b1) begin
        acc++;
        e.data = 32'hDEADBEEF; e.err = 1'b0; e.cyc = cyc + 2;
        q0.push_back(e);
      end else if (acc == 1) low++;
    end
    @(posedge clk); #1;
    bus0.iob_valid = 1'b0;
    check("held_accepts", acc, 32'd2);
    check("held_ready_low_cycles", low, 32'd2);
    wait_idle(0, low);

    // 3b: zero wait states
    write(1, 32'h40, 32'h5A5A5A5A, 4'hF);
    read(1, 32'h40, 32'h5A5A5A5A, 1'b0, 0, 0);
    wait_idle(1, low);
    check("ws0_ready_low_cycles", low, 32'd1);

    // 4: clock enable low for 3 cycles during WAIT
    read(0, 32'h20, 32'h1122AA44, 1'b0, 1, 3);
    cke0 = 1'b0;
    repeat (3) @(posedge clk);
    #1; cke0 = 1'b1;
    wait_idle(0, low);
    check("cke_stall_ready_low_cycles", low, 32'd2);

    // 4b: write presented with cke low must not reach RAM
    bus0.iob_valid = 1'b1; bus0.iob_addr = 32'h10; bus0.iob_wdata = 32'hFFFFFFFF;
    bus0.iob_wstrb = 4'hF; cke0 = 1'b0;
    @(posedge clk); #1;
    drop(0); cke0 = 1'b1;
    read(0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0);
    wait_idle(0, low);

    // 5: reset while in WAIT drops the read
    read(0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0);
    rst_n0 = 1'b0;
    q0.delete();
    @(posedge clk); #1;
    rst_n0 = 1'b1;
    @(negedge clk);
    check("ready_after_midread_reset", {31'd0, bus0.iob_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    read(0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0);
    wait_idle(0, low);

    // 6: out-of-range write then reads
    write(0, 32'h8000_0010, 32'h12345678, 4'hF);
    @(negedge clk);
    check("oor_write_err_pulse", {31'd0, err0}, {31'd0, CHK});
    @(posedge clk); #1;
    @(negedge clk);
    check("err_pulse_cleared", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    alias_val = CHK ? 32'hDEADBEEF : 32'h12345678;
    read(0, 32'h10, alias_val, 1'b0, 1, 0);
    wait_idle(0, low);
    read(0, 32'h8000_0010, CHK ? 32'h0 : alias_val, CHK, 1, 0);
    wait_idle(0, low);

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    check("dut0_queue_drained", q0.size(), 32'd0);
    check("dut1_queue_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
